// File: rtl/dequant_zigzag_buf_pkg.sv
// Shared definitions for the dequantise / zigzag-reorder stage: widths,
// zigzag position maps, the default (JPEG luminance) quantisation table and
// the controller state encoding.
package dequant_zigzag_buf_pkg;

  localparam int COEF_W = 12;
  localparam int Q_W    = 8;
  localparam int OUT_W  = 22;
  localparam int ROW_W  = 8 * OUT_W;
  // Signed coef times zero-extended Q; the true range fits in 20 bits, the
  // extra bit only comes from the zero-extension of the unsigned operand.
  localparam int PROD_W = COEF_W + Q_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RUN   = 2'd2
  } ctrl_state_t;

  // Natural-order row of zigzag index k.
  localparam logic [2:0] ZZ_ROW [64] = '{
    3'd0, 3'd0, 3'd1, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3,
    3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4,
    3'd5, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1,
    3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd4,
    3'd3, 3'd2, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7,
    3'd6, 3'd5, 3'd4, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6,
    3'd5, 3'd6, 3'd7, 3'd7
  };

  // Natural-order column of zigzag index k.
  localparam logic [2:0] ZZ_COL [64] = '{
    3'd0, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd1, 3'd0,
    3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1,
    3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6,
    3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4,
    3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd3,
    3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd4, 3'd5, 3'd6,
    3'd7, 3'd7, 3'd6, 3'd7
  };

  // Standard JPEG luminance table, natural (row-major) order.
  localparam logic [Q_W-1:0] Q_NAT [64] = '{
    8'd16, 8'd11, 8'd10, 8'd16, 8'd24,  8'd40,  8'd51,  8'd61,
    8'd12, 8'd12, 8'd14, 8'd19, 8'd26,  8'd58,  8'd60,  8'd55,
    8'd14, 8'd13, 8'd16, 8'd24, 8'd40,  8'd57,  8'd69,  8'd56,
    8'd14, 8'd17, 8'd22, 8'd29, 8'd51,  8'd87,  8'd80,  8'd62,
    8'd18, 8'd22, 8'd37, 8'd56, 8'd68,  8'd109, 8'd103, 8'd77,
    8'd24, 8'd35, 8'd55, 8'd64, 8'd81,  8'd104, 8'd113, 8'd92,
    8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
    8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99
  };

  // Default quantiser for zigzag index k.
  function automatic logic [Q_W-1:0] q_default(input logic [5:0] k);
    return Q_NAT[{ZZ_ROW[k], ZZ_COL[k]}];
  endfunction

endpackage

// File: rtl/dequant_zigzag_buf_pingpong_rowbuf.sv
// Two banks of 8 rows x 8 coefficients. Single-coefficient write port,
// combinational whole-row read port.
module dequant_zigzag_buf_pingpong_rowbuf
  import dequant_zigzag_buf_pkg::*;
(
  input  logic             clk,
  input  logic             wr_en,
  input  logic             wr_bank,
  input  logic [2:0]       wr_row,
  input  logic [2:0]       wr_col,
  input  logic [OUT_W-1:0] wr_data,
  input  logic             rd_bank,
  input  logic [2:0]       rd_row,
  output logic [ROW_W-1:0] rd_data
);

  logic [OUT_W-1:0] mem [2][8][8];

  // Element write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank][wr_row][wr_col] <= wr_data;
  end

  // Assemble the addressed row, column c in slice c.
  always_comb begin
    rd_data = '0;
    for (int c = 0; c < 8; c++) rd_data[c*OUT_W +: OUT_W] = mem[rd_bank][rd_row][c];
  end

endmodule

// File: rtl/dequant_zigzag_buf.sv
// Dequantise zigzag-ordered coefficients into a ping-pong block buffer and
// hand full blocks to the IDCT (blk_start / idct_done).
// Build option QTABLE_LOAD_EN: adds a writable quantisation table
// (qt_we/qt_addr/qt_data); otherwise the default table is a constant ROM.
//
// Handshake: a coefficient transfers on a rising edge where coef_valid and
// coef_ready are both 1; coef_ready depends only on registered state, never
// on coef_valid.
module dequant_zigzag_buf
  import dequant_zigzag_buf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [COEF_W-1:0] coef_in,
  input  logic              coef_valid,
  output logic              coef_ready,
  input  logic [2:0]        rd_row,
  output logic [ROW_W-1:0]  rd_data,
  output logic              blk_start,
  input  logic              idct_done,
`ifdef QTABLE_LOAD_EN
  input  logic              qt_we,
  input  logic [5:0]        qt_addr,
  input  logic [Q_W-1:0]    qt_data,
`endif
  output logic [1:0]        bank_full
);

  ctrl_state_t              state_q, state_d;
  logic                     wb, rb, idct_busy, ready_en;
  logic [5:0]               k;
  logic [1:0]               bank_full_d;
  logic                     xfer, last_xfer, done_take;
  logic [Q_W-1:0]           q_k;
  logic signed [PROD_W-1:0] prod;
  logic [OUT_W-1:0]         wr_data;

  assign coef_ready = ready_en & ~bank_full[wb];
  assign xfer       = coef_valid & coef_ready;
  assign last_xfer  = xfer & (k == 6'd63);
  assign done_take  = (state_q == RUN) & idct_done;
  assign blk_start  = (state_q == ISSUE);

`ifdef QTABLE_LOAD_EN
  logic [Q_W-1:0] q_tab [64];

  // Quantiser table: default on reset, host writes otherwise. A transfer in
  // the same cycle as a write reads the pre-write entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 64; i++) q_tab[i] <= q_default(6'(i));
    end else if (qt_we) begin
      q_tab[qt_addr] <= qt_data;
    end
  end

  assign q_k = q_tab[k];
`else
  assign q_k = q_default(k);
`endif

  assign prod    = PROD_W'($signed(coef_in)) * PROD_W'($signed({1'b0, q_k}));
  assign wr_data = {{(OUT_W-PROD_W){prod[PROD_W-1]}}, prod};

  dequant_zigzag_buf_pingpong_rowbuf u_pingpong_rowbuf (
    .clk     (clk),
    .wr_en   (xfer),
    .wr_bank (wb),
    .wr_row  (ZZ_ROW[k]),
    .wr_col  (ZZ_COL[k]),
    .wr_data (wr_data),
    .rd_bank (rb),
    .rd_row  (rd_row),
    .rd_data (rd_data)
  );

  // Full flags: release of the read bank and completion of the write bank
  // may coincide; they always refer to different banks.
  always_comb begin
    bank_full_d = bank_full;
    if (done_take) bank_full_d[rb] = 1'b0;
    if (last_xfer) bank_full_d[wb] = 1'b1;
  end

  // Controller next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bank_full[rb] && !idct_busy) state_d = ISSUE;
      ISSUE:   state_d = RUN;
      RUN:     if (idct_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bank pointers, zigzag index, full flags, controller state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      ready_en  <= 1'b0;
      wb        <= 1'b0;
      rb        <= 1'b0;
      k         <= 6'd0;
      bank_full <= 2'b00;
      idct_busy <= 1'b0;
    end else begin
      state_q   <= state_d;
      ready_en  <= 1'b1;
      bank_full <= bank_full_d;
      if (xfer)      k  <= k + 6'd1;
      if (last_xfer) wb <= ~wb;
      if (done_take) rb <= ~rb;
      if (state_q == ISSUE)  idct_busy <= 1'b1;
      else if (done_take)    idct_busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dequant_zigzag_buf.sv
// Directed bench for dequant_zigzag_buf: reset, vector table of hand-computed
// coefficients, full-block model compare, backpressure, simultaneous
// done/last-write, reset mid-load. Also exercises the QTABLE_LOAD_EN ports
// when that macro is defined.
module tb_dequant_zigzag_buf;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [11:0]  coef_in;
  logic         coef_valid, coef_ready, blk_start, idct_done;
  logic [2:0]   rd_row;
  logic [175:0] rd_data;
  logic [1:0]   bank_full;
`ifdef QTABLE_LOAD_EN
  logic         qt_we;
  logic [5:0]   qt_addr;
  logic [7:0]   qt_data;
`endif

  dequant_zigzag_buf dut (
    .clk        (clk),
    .rst        (rst),
    .coef_in    (coef_in),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .rd_row     (rd_row),
    .rd_data    (rd_data),
    .blk_start  (blk_start),
    .idct_done  (idct_done),
`ifdef QTABLE_LOAD_EN
    .qt_we      (qt_we),
    .qt_addr    (qt_addr),
    .qt_data    (qt_data),
`endif
    .bank_full  (bank_full)
  );

  localparam int Q_JPEG [64] = '{
    16, 11, 10, 16, 24, 40, 51, 61,
    12, 12, 14, 19, 26, 58, 60, 55,
    14, 13, 16, 24, 40, 57, 69, 56,
    14, 17, 22, 29, 51, 87, 80, 62,
    18, 22, 37, 56, 68, 109, 103, 77,
    24, 35, 55, 64, 81, 104, 113, 92,
    49, 64, 78, 87, 103, 121, 120, 101,
    72, 92, 95, 98, 112, 100, 103, 99
  };

  typedef struct {
    int row;
    int col;
    int exp;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0, start_cnt = 0, last_start_cyc = -1, xfer_cyc = 0;
  int zz_r [64];
  int zz_c [64];
  int q_model [64];
  logic signed [11:0] stim [64];
  logic [175:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (blk_start === 1'b1) begin
      start_cnt      <= start_cnt + 1;
      last_start_cyc <= cyc;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [175:0] act, input logic [175:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Independent zigzag walk along anti-diagonals.
  function automatic void build_zigzag();
    int k = 0;
    for (int s = 0; s < 15; s++) begin
      if (s % 2 == 0) begin
        for (int r = (s < 8) ? s : 7; r >= 0 && s - r <= 7; r--) begin
          zz_r[k] = r; zz_c[k] = s - r; k++;
        end
      end else begin
        for (int r = (s < 8) ? 0 : s - 7; r <= 7 && s - r >= 0; r++) begin
          zz_r[k] = r; zz_c[k] = s - r; k++;
        end
      end
    end
  endfunction

  task automatic push_model();
    logic [21:0]  m [8][8];
    logic [175:0] row;
    int p;
    for (int k = 0; k < 64; k++) begin
      p = int'(stim[k]) * q_model[zz_r[k]*8 + zz_c[k]];
      m[zz_r[k]][zz_c[k]] = p[21:0];
    end
    for (int r = 0; r < 8; r++) begin
      row = '0;
      for (int c = 0; c < 8; c++) row[c*22 +: 22] = m[r][c];
      exp_q.push_back(row);
    end
  endtask

  task automatic check_bank(input string tag);
    logic [175:0] e;
    for (int r = 0; r < 8; r++) begin
      rd_row = 3'(r);
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("%s_row%0d", tag, r), rd_data, e);
      @(posedge clk); #1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_coef(input logic signed [11:0] v, input logic done_now);
    int w = 0;
    coef_in = v;
    coef_valid = 1'b1;
    while (!coef_ready && w < 300) begin
      @(posedge clk); #1; w++;
    end
    if (!coef_ready) check("ready_wait", coef_ready, 1'b1);
    idct_done = done_now;
    @(posedge clk); #1;
    xfer_cyc   = cyc;
    coef_valid = 1'b0;
    idct_done  = 1'b0;
  endtask

  task automatic send_block(input int first, input int last, input logic done_last);
    for (int k = first; k <= last; k++) send_coef(stim[k], (k == 63) ? done_last : 1'b0);
  endtask

  task automatic check_start(input string tag, input int base);
    repeat (4) begin @(posedge clk); #1; end
    check({tag, "_start_cnt"}, start_cnt - base, 1);
    check({tag, "_start_lat"}, last_start_cyc - xfer_cyc, 1);
  endtask

  task automatic pulse_done();
    idct_done = 1'b1;
    @(posedge clk); #1;
    idct_done = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs [12];
  int base, done_cyc;
  logic [21:0] e22;

  initial begin
    vecs[0]  = '{0, 0, -32768};
    vecs[1]  = '{0, 1, -341};
    vecs[2]  = '{1, 0, -360};
    vecs[3]  = '{2, 0, -406};
    vecs[4]  = '{1, 1, -336};
    vecs[5]  = '{0, 2, -270};
    vecs[6]  = '{3, 4, -51};
    vecs[7]  = '{4, 3, 0};
    vecs[8]  = '{5, 2, 55};
    vecs[9]  = '{7, 0, 216};
    vecs[10] = '{0, 7, -244};
    vecs[11] = '{7, 7, 202653};

    build_zigzag();
    for (int i = 0; i < 64; i++) q_model[i] = Q_JPEG[i];
    coef_in = '0; coef_valid = 1'b0; idct_done = 1'b0; rd_row = '0;
`ifdef QTABLE_LOAD_EN
    qt_we = 1'b0; qt_addr = '0; qt_data = '0;
`endif

    // Reset
    repeat (3) begin @(posedge clk); #1; end
    check("rst_ready", coef_ready, 1'b0);
    check("rst_start", blk_start, 1'b0);
    check("rst_full", bank_full, 2'b00);
    rst = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", coef_ready, 1'b1);

`ifdef QTABLE_LOAD_EN
    // Unit table, coef = k
    for (int k = 0; k < 64; k++) begin
      qt_we = 1'b1; qt_addr = 6'(k); qt_data = 8'd1;
      @(posedge clk); #1;
    end
    qt_we = 1'b0;
    for (int i = 0; i < 64; i++) q_model[i] = 1;
    for (int k = 0; k < 64; k++) stim[k] = 12'(k);
    push_model();
    base = start_cnt;
    send_block(0, 63, 1'b0);
    check_start("unit", base);
    rd_row = 3'd0;
    @(negedge clk);
    check("unit_r0c0", rd_data[21:0], 22'd0);
    check("unit_r0c1", rd_data[43:22], 22'd1);
    @(posedge clk); #1;
    rd_row = 3'd1;
    @(negedge clk);
    check("unit_r1c0", rd_data[21:0], 22'd2);
    @(posedge clk); #1;
    check_bank("unit");

    // Extreme product: -2048 * 255
    pulse_reset();
    qt_we = 1'b1; qt_addr = 6'd0; qt_data = 8'd255;
    @(posedge clk); #1;
    qt_we = 1'b0;
    for (int k = 0; k < 64; k++) stim[k] = '0;
    stim[0] = -12'sd2048;
    send_block(0, 63, 1'b0);
    rd_row = 3'd0;
    @(negedge clk);
    check("sign_q255", rd_data[21:0], 22'h380800);
    @(posedge clk); #1;
    pulse_reset();
    for (int i = 0; i < 64; i++) q_model[i] = Q_JPEG[i];
`endif

    // Block A into bank 0, default table, vector table + model
    for (int k = 0; k < 64; k++) stim[k] = 12'(k - 32);
    stim[0]  = -12'sd2048;
    stim[63] = 12'sd2047;
    push_model();
    base = start_cnt;
    send_block(0, 63, 1'b0);
    check_start("blkA", base);
    check("A_full", bank_full, 2'b01);
    check("A_ready", coef_ready, 1'b1);
    for (int i = 0; i < 12; i++) begin
      rd_row = 3'(vecs[i].row);
      @(negedge clk);
      e22 = vecs[i].exp[21:0];
      check($sformatf("vec%0d_r%0dc%0d", i, vecs[i].row, vecs[i].col),
            rd_data[vecs[i].col*22 +: 22], e22);
      @(posedge clk); #1;
    end
    check_bank("blkA");

    // Block B into bank 1 while IDCT busy: both banks full, no new start
    for (int k = 0; k < 64; k++) stim[k] = 12'((k * 37) % 200 - 100);
    push_model();
    base = start_cnt;
    send_block(0, 63, 1'b0);
    @(posedge clk); #1;
    check("bp_full", bank_full, 2'b11);
    check("bp_ready", coef_ready, 1'b0);
    check("bp_no_start", start_cnt - base, 0);

    // 129th coefficient held until idct_done
    for (int k = 0; k < 64; k++) stim[k] = -12'(k);
    stim[0] = 12'sd7;
    coef_in = stim[0];
    coef_valid = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_hold", coef_ready, 1'b0);
    end
    base = start_cnt;
    pulse_done();
    done_cyc = cyc;
    check("bp_full_after_done", bank_full, 2'b10);
    check("bp_ready_after_done", coef_ready, 1'b1);
    send_coef(stim[0], 1'b0);
    check_bank("blkB");
    check("bp_start_cnt", start_cnt - base, 1);
    check("bp_start_lat", last_start_cyc - done_cyc, 1);

    // Rest of block C into bank 0, then release bank 1
    send_block(1, 63, 1'b0);
    push_model();
    @(posedge clk); #1;
    check("C_full", bank_full, 2'b11);
    pulse_done();
    base = start_cnt;
    check("C_full_after_done", bank_full, 2'b01);
    check_bank("blkC");
    check("C_start_cnt", start_cnt - base, 1);

    // Block D into bank 1 with idct_done on its last transfer
    for (int k = 0; k < 64; k++) stim[k] = 12'(5 * k - 150);
    push_model();
    base = start_cnt;
    send_block(0, 63, 1'b1);
    check("sim_full", bank_full, 2'b10);
    check("sim_ready", coef_ready, 1'b1);
    check_start("sim", base);
    check_bank("blkD");

    // Reset after 30 coefficients, then a fresh block
    for (int k = 0; k < 64; k++) stim[k] = 12'(k + 1);
    send_block(0, 29, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("mid_rst_full", bank_full, 2'b00);
    check("mid_rst_ready", coef_ready, 1'b0);
    @(posedge clk); #1;
    check("mid_ready", coef_ready, 1'b1);
    for (int k = 0; k < 64; k++) stim[k] = 12'(3 * k - 90);
    push_model();
    base = start_cnt;
    send_block(0, 63, 1'b0);
    check_start("mid", base);
    check("mid_full", bank_full, 2'b01);
    check_bank("blkF");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
